// File: rtl/zeroheti_dbg_sba_bridge.sv
// zeroheti_dbg_sba_bridge
//
// Bridge between the debug module's system-bus-access manager port and the
// OBI system crossbar. It limits the number of accepted-but-unanswered
// requests, forwards real bus errors, and flags responses nobody asked for.
// With ZEROHETI_SBA_TIMEOUT_EN defined, a response watchdog is added. If the
// subordinate stays silent too long, the bridge answers the DM with an error
// plus a one-cycle other_err pulse. It then drains stray responses for a
// while before issuing again.
//
// Configuration macro: ZEROHETI_SBA_TIMEOUT_EN (undefined: no watchdog,
// sba_other_err_o tied low, TimeoutCycles ignored).
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   sba_*_i / sba_*_o    DM manager side: request, grant, response, errors
//   obi_*_o / obi_*_i    crossbar side: OBI A-channel out, grant/R-channel in
//   proto_err_o          sticky: a response arrived with nothing outstanding
module zeroheti_dbg_sba_bridge #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned TimeoutCycles  = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sba_req_i,
    input  logic [AddrWidth-1:0]   sba_addr_i,
    input  logic                   sba_we_i,
    input  logic [DataWidth-1:0]   sba_wdata_i,
    input  logic [DataWidth/8-1:0] sba_be_i,
    output logic                   sba_gnt_o,
    output logic                   sba_rvalid_o,
    output logic [DataWidth-1:0]   sba_rdata_o,
    output logic                   sba_err_o,
    output logic                   sba_other_err_o,
    output logic                   obi_req_o,
    output logic [AddrWidth-1:0]   obi_addr_o,
    output logic                   obi_we_o,
    output logic [DataWidth-1:0]   obi_wdata_o,
    output logic [DataWidth/8-1:0] obi_be_o,
    input  logic                   obi_gnt_i,
    input  logic                   obi_rvalid_i,
    input  logic [DataWidth-1:0]   obi_rdata_i,
    input  logic                   obi_err_i,
    output logic                   proto_err_o
);

    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

`ifdef ZEROHETI_SBA_TIMEOUT_EN
    localparam int unsigned TmrWidth = $clog2(TimeoutCycles);
    localparam logic [TmrWidth-1:0] TmrLast = TmrWidth'(TimeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, BUSY, TIMEOUT, DRAIN} state_e;

    logic [TmrWidth-1:0] tmr_q, tmr_d;
    logic [TmrWidth-1:0] drain_q, drain_d;
`else
    typedef enum logic {IDLE, BUSY} state_e;

    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TimeoutCycles > 1);
`endif

    state_e              state_q, state_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                proto_err_q;
    logic                run;
    logic                can_issue;
    logic                accept;
    logic                rsp_counted;
    logic                rsp_unsolicited;
    logic                timeout_pulse;

    // Only IDLE/BUSY issue requests or account for responses; in the
    // recovery states every response is treated as a leftover and swallowed.
    assign run             = (state_q == IDLE) || (state_q == BUSY);
    assign rsp_counted     = run && obi_rvalid_i && (count_q != '0);
    assign rsp_unsolicited = run && obi_rvalid_i && (count_q == '0);
    // A response in the same cycle frees a slot, so a full bridge can still
    // grant without a bubble.
    assign can_issue       = run && ((count_q < MaxCnt) || obi_rvalid_i);
    assign accept          = obi_req_o && obi_gnt_i;

`ifdef ZEROHETI_SBA_TIMEOUT_EN
    assign timeout_pulse = (state_q == TIMEOUT);
`else
    assign timeout_pulse = 1'b0;
`endif

    assign obi_req_o   = sba_req_i && can_issue;
    assign sba_gnt_o   = obi_gnt_i && can_issue;
    assign obi_addr_o  = sba_addr_i;
    assign obi_we_o    = sba_we_i;
    assign obi_wdata_o = sba_wdata_i;
    assign obi_be_o    = sba_be_i;

    assign sba_rvalid_o    = rsp_counted || timeout_pulse;
    assign sba_rdata_o     = rsp_counted ? obi_rdata_i : '0;
    assign sba_err_o       = (rsp_counted && obi_err_i) || timeout_pulse;
    assign sba_other_err_o = timeout_pulse;
    assign proto_err_o     = proto_err_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef ZEROHETI_SBA_TIMEOUT_EN
        tmr_d   = '0;
        drain_d = drain_q;
`endif
        case (state_q)
            IDLE, BUSY: begin
                if (accept && !rsp_counted) begin
                    count_d = count_q + 1'b1;
                end else if (!accept && rsp_counted) begin
                    count_d = count_q - 1'b1;
                end
                state_d = (count_d == '0) ? IDLE : BUSY;
`ifdef ZEROHETI_SBA_TIMEOUT_EN
                // tmr_q holds the number of cycles elapsed since the last
                // accept-from-idle or response, so the terminal value is
                // reached TimeoutCycles-1 cycles later and the error pulse
                // lands exactly TimeoutCycles cycles after the event. A
                // response in the terminal cycle wins over the timeout.
                if ((state_q == BUSY) && !rsp_counted && (tmr_q == TmrLast)) begin
                    state_d = TIMEOUT;
                end else if (state_d == BUSY) begin
                    tmr_d = (rsp_counted || (state_q == IDLE)) ? TmrWidth'(1)
                                                               : tmr_q + 1'b1;
                end
`endif
            end
`ifdef ZEROHETI_SBA_TIMEOUT_EN
            TIMEOUT: begin
                count_d = '0;
                drain_d = TmrLast;
                state_d = DRAIN;
            end
            DRAIN: begin
                // Leave when the decrement lands on zero: TimeoutCycles-1
                // drain cycles in total.
                drain_d = drain_q - 1'b1;
                if (drain_q <= TmrWidth'(1)) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            count_q     <= '0;
            proto_err_q <= 1'b0;
`ifdef ZEROHETI_SBA_TIMEOUT_EN
            tmr_q       <= '0;
            drain_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_q || rsp_unsolicited;
`ifdef ZEROHETI_SBA_TIMEOUT_EN
            tmr_q       <= tmr_d;
            drain_q     <= drain_d;
`endif
        end
    end

endmodule
